system_top_sdiv_28s_16s_seq: RTL

SYSTEM_TOP_SDIV_28S_16S_SEQ -- requirements
Module: system_top_sdiv_28s_16s_seq

---
 rtl/system_top_div_pkg.sv | 20 ++
 rtl/system_top_div_step.sv | 29 ++
 rtl/system_top_sdiv_28s_16s_seq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/system_top_div_pkg.sv
// Shared constants and FSM encoding for the sequential signed divider.
//   DIN0_W : dividend / quotient width
//   DIN1_W : divisor / remainder width
//   CNT_W  : iteration counter width (covers DIN0_W steps)
//   state_t: divider control states
package system_top_div_pkg;

  localparam int unsigned DIN0_W = 28;
  localparam int unsigned DIN1_W = 16;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/system_top_div_step.sv
// One restoring-division iteration (combinational).
//   rem_in  : partial remainder before this step
//   bit_in  : next dividend bit, MSB first
//   divisor : divisor magnitude
//   rem_out : partial remainder after this step
//   q_bit   : quotient bit produced by this step
module system_top_div_step
  import system_top_div_pkg::*;
(
  input  logic [DIN1_W-1:0] rem_in,
  input  logic              bit_in,
  input  logic [DIN1_W-1:0] divisor,
  output logic [DIN1_W-1:0] rem_out,
  output logic              q_bit
);

  logic [DIN1_W:0] shifted;
  logic [DIN1_W:0] diff;

  // rem_in < divisor <= 2^(DIN1_W-1), so shifted - divisor always fits a
  // DIN1_W+1 bit two's complement value and its MSB is the borrow.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[DIN1_W];
    rem_out = q_bit ? diff[DIN1_W-1:0] : shifted[DIN1_W-1:0];
  end

endmodule

// File: rtl/system_top_sdiv_28s_16s_seq.sv
// Sequential signed divider, truncating toward zero, fixed 30-cycle latency.
//   ap_clk, ap_rst        : clock, asynchronous active-high reset
//   din0, din1, in_valid  : signed dividend / divisor and their valid
//   in_ready              : high only while idle
//   dout_quot, dout_rem   : signed quotient / remainder (remainder follows dividend sign)
//   dbz, ovf              : divide-by-zero and quotient-overflow flags
//   out_valid, out_ready  : result handshake; result held until accepted
module system_top_sdiv_28s_16s_seq
  import system_top_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [din0_WIDTH-1:0] dout_quot,
  output logic [din1_WIDTH-1:0] dout_rem,
  output logic                  dbz,
  output logic                  ovf,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [DIN0_W-1:0] Q_MAX = {1'b0, {(DIN0_W-1){1'b1}}};
  localparam logic [DIN0_W-1:0] Q_MIN = {1'b1, {(DIN0_W-1){1'b0}}};

  state_t state, state_next;

  logic [CNT_W-1:0]  cnt;
  logic [DIN0_W-1:0] op0, q;
  logic [DIN1_W-1:0] op1, b_mag, rem;
  logic [DIN0_W:0]   a_mag;
  logic              q_neg, r_neg, dbz_r, ovf_r;
  logic [DIN1_W-1:0] step_rem;
  logic              step_q;
  logic              accept, last_step;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_ready & in_valid;
  assign last_step = (cnt == CNT_W'(DIN0_W - 1));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (in_valid)  state_next = S_ABS;
      S_ABS:                 state_next = S_ITER;
      S_ITER: if (last_step) state_next = S_FIX;
      S_FIX:                 state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default:               state_next = S_IDLE;
    endcase
  end

  system_top_div_step u_step (
    .rem_in  (rem),
    .bit_in  (a_mag[DIN0_W-1]),
    .divisor (b_mag),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cnt       <= '0;
      op0       <= '0;
      op1       <= '0;
      a_mag     <= '0;
      b_mag     <= '0;
      rem       <= '0;
      q         <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dbz_r     <= 1'b0;
      ovf_r     <= 1'b0;
      dout_quot <= '0;
      dout_rem  <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op0 <= din0;
            op1 <= din1;
          end
        end
        S_ABS: begin
          // One extra bit so |-2^27| is representable without wrap.
          a_mag <= op0[DIN0_W-1] ? ('0 - {op0[DIN0_W-1], op0}) : {1'b0, op0};
          b_mag <= op1[DIN1_W-1] ? ('0 - op1) : op1;
          q_neg <= op0[DIN0_W-1] ^ op1[DIN1_W-1];
          r_neg <= op0[DIN0_W-1];
          dbz_r <= (op1 == '0);
          ovf_r <= (op0 == Q_MIN) && (op1 == '1);
          rem   <= '0;
          q     <= '0;
          cnt   <= '0;
        end
        S_ITER: begin
          rem   <= step_rem;
          q     <= {q[DIN0_W-2:0], step_q};
          a_mag <= a_mag << 1;
          cnt   <= cnt + CNT_W'(1);
        end
        S_FIX: begin
          dbz <= dbz_r;
          ovf <= ovf_r;
          if (dbz_r) begin
            dout_quot <= r_neg ? Q_MIN : Q_MAX;
            dout_rem  <= '0;
          end else if (ovf_r) begin
            dout_quot <= Q_MAX;
            dout_rem  <= '0;
          end else begin
            dout_quot <= q_neg ? ('0 - q) : q;
            dout_rem  <= r_neg ? ('0 - rem) : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
